// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the issue logic and the RV32M multiply/divide unit.
// The issuer drives the operands and start pulse. The unit returns busy, done and the result.
interface muldiv_unit_if #(
  parameter int N = 32
);
  logic         start_in;
  logic [2:0]   funct3_in;
  logic [N-1:0] rs1_in;
  logic [N-1:0] rs2_in;
  logic         busy_out;
  logic         done_out;
  logic [N-1:0] result_out;

  modport master (
    output start_in, funct3_in, rs1_in, rs2_in,
    input  busy_out, done_out, result_out
  );

  modport slave (
    input  start_in, funct3_in, rs1_in, rs2_in,
    output busy_out, done_out, result_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. It runs one shift-add or restoring-divide step per
// cycle on operand magnitudes, then fixes up sign and special cases in a final cycle.
module muldiv_unit #(
  parameter int N = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [N-1:0]     a_q, a_d, b_q, b_d;
  logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [2*N-1:0]   acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     result_q, result_d;
  logic             done_q, done_d;

  // Request decode: the signedness of each operand depends on the op.
  op_e          op_in;
  logic         sa_in, sb_in;
  logic [N-1:0] a_mag, b_mag;

  assign op_in = op_e'(bus.funct3_in);
  assign sa_in = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && bus.rs1_in[N-1];
  assign sb_in = (op_in inside {OP_MULH, OP_DIV, OP_REM}) && bus.rs2_in[N-1];
  assign a_mag = sa_in ? -bus.rs1_in : bus.rs1_in;
  assign b_mag = sb_in ? -bus.rs2_in : bus.rs2_in;

  // acc holds {partial product high, multiplier} or {remainder, dividend/quotient}.
  logic [N:0]       add_sum, div_shift, div_diff;
  logic             div_ge, b_zero, div_ovf;
  logic [2*N-1:0]   prod_s;
  logic [N-1:0]     quot_s, rem_s, rs1_orig;

  assign add_sum   = {1'b0, acc_q[2*N-1:N]} + {1'b0, (acc_q[0] ? a_q : {N{1'b0}})};
  assign div_shift = {acc_q[2*N-1:N], acc_q[N-1]};
  assign div_ge    = div_shift >= {1'b0, b_q};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign prod_s    = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
  assign quot_s    = (neg_a_q ^ neg_b_q) ? -acc_q[N-1:0] : acc_q[N-1:0];
  assign rem_s     = neg_a_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];
  assign rs1_orig  = neg_a_q ? -a_q : a_q;
  assign b_zero    = (b_q == '0);
  assign div_ovf   = neg_a_q && neg_b_q && (a_q == {1'b1, {(N-1){1'b0}}}) && (b_q == N'(1));

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start_in) begin
          state_d = CALC;
          op_d    = op_in;
          a_d     = a_mag;
          b_d     = b_mag;
          neg_a_d = sa_in;
          neg_b_d = sb_in;
          cnt_d   = '0;
          acc_d   = op_in[2] ? {{N{1'b0}}, a_mag} : {{N{1'b0}}, b_mag};
        end
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (op_q[2]) begin
          acc_d = div_ge ? {div_diff[N-1:0], acc_q[N-2:0], 1'b1}
                         : {div_shift[N-1:0], acc_q[N-2:0], 1'b0};
        end else begin
          acc_d = {add_sum, acc_q[N-1:1]};
        end
        if (cnt_q == CW'(N - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        case (op_q)
          OP_MUL:                       result_d = prod_s[N-1:0];
          OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_s[2*N-1:N];
          OP_DIV, OP_DIVU:              result_d = b_zero  ? {N{1'b1}} :
                                                   div_ovf ? {1'b1, {(N-1){1'b0}}} : quot_s;
          OP_REM, OP_REMU:              result_d = b_zero  ? rs1_orig :
                                                   div_ovf ? {N{1'b0}} : rem_s;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst_in) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy_out   = (state_q != IDLE);
  assign bus.done_out   = done_q;
  assign bus.result_out = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit. It runs directed RV32M corner cases and then random
// ops, and compares the results against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_unit_if #(.N(N)) bus ();
  muldiv_unit #(.N(N)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          last_done_cyc = 0;
  logic [31:0] last_res = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // The result is computed straight from the RV32M definitions with wide integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int          ia, ib;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    r  = '0;
    p  = '0;
    case (op)
      3'd0: begin p = ua * ub; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF :
                (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(ia / ib);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a :
                (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(ia % ib);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  task automatic drive_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start_in  = 1'b1;
    bus.funct3_in = op;
    bus.rs1_in    = a;
    bus.rs2_in    = b;
  endtask

  task automatic scramble_req();
    bus.start_in  = 1'b0;
    bus.funct3_in = 3'($urandom);
    bus.rs1_in    = $urandom;
    bus.rs2_in    = $urandom;
  endtask

  // Issue one op from the current cycle and wait (bounded) for its done pulse. If poke >= 0, a
  // competing start with random operands is raised for one edge while the unit is busy.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag, input bit b2b, input int poke);
    int e, busy_n;
    bit hold_ok, seen;
    drive_req(op, a, b);
    @(posedge clk); #1;
    scramble_req();
    check({tag, "/done_low"}, 32'(bus.done_out), 32'd0);
    busy_n  = bus.busy_out ? 1 : 0;
    hold_ok = 1'b1;
    seen    = 1'b0;
    e       = 0;
    while (e < 100 && !seen) begin
      if (e == poke) begin
        drive_req(3'($urandom), $urandom, $urandom);
      end else begin
        bus.start_in = 1'b0;
      end
      @(posedge clk); #1;
      e++;
      if (bus.busy_out) busy_n++;
      if (bus.done_out) seen = 1'b1;
      else if (bus.result_out !== last_res) hold_ok = 1'b0;
    end
    bus.start_in = 1'b0;
    check({tag, "/latency"}, 32'(e), 32'(N + 1));
    check({tag, "/busy_cycles"}, 32'(busy_n), 32'(N + 1));
    check({tag, "/hold"}, 32'(hold_ok), 32'd1);
    check({tag, "/result"}, bus.result_out, exp);
    if (b2b) check({tag, "/spacing"}, 32'(cyc - last_done_cyc), 32'(N + 2));
    last_done_cyc = cyc;
    last_res      = bus.result_out;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  localparam int ND = 14;
  logic [2:0]  d_op [ND] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7,
                            3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
  logic [31:0] d_a  [ND] = '{32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                            32'd5, 32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b  [ND] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'd2, 32'd2, 32'd7, 32'd7,
                            32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] d_exp[ND] = '{32'hFFFF_FFEB, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                            32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                            32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    bit          seen;
    int          gap;

    rst           = 1'b1;
    bus.start_in  = 1'b0;
    bus.funct3_in = '0;
    bus.rs1_in    = '0;
    bus.rs2_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/busy", 32'(bus.busy_out), 32'd0);
    check("reset/done", 32'(bus.done_out), 32'd0);
    check("reset/result", bus.result_out, 32'd0);
    rst = 1'b0;

    // Directed corner cases, each issued in the done cycle of the previous one.
    for (int i = 0; i < ND; i++)
      run_op(d_op[i], d_a[i], d_b[i], d_exp[i], $sformatf("dir%0d", i), i != 0, -1);

    // Starts raised mid-calculation and on the fix-up edge must be ignored.
    run_op(3'd5, 32'd1000, 32'd10, 32'd100, "ignore_mid", 1'b1, 5);
    run_op(3'd7, 32'd1000, 32'd7, 32'd6, "ignore_fix", 1'b1, N);

    // Reset during iteration 10 of a DIV aborts it without a done pulse.
    drive_req(3'd4, 32'hFFFF_FF00, 32'd3);
    @(posedge clk); #1;
    scramble_req();
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort/busy", 32'(bus.busy_out), 32'd0);
    check("abort/result", bus.result_out, 32'd0);
    check("abort/done", 32'(bus.done_out), 32'd0);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (N + 5) begin
      @(posedge clk); #1;
      if (bus.done_out) seen = 1'b1;
    end
    check("abort/no_done", 32'(seen), 32'd0);
    last_res = '0;
    run_op(3'd0, 32'd3, 32'd4, 32'd12, "after_abort", 1'b0, -1);

    // Random ops, sometimes back to back and sometimes separated by idle cycles.
    for (int i = 0; i < 150; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = pick_operand();
      b   = pick_operand();
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
      run_op(op, a, b, model(op, a, b), $sformatf("rnd%0d_op%0d", i, op), gap == 0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit for the riscv32 core.
- Accepts two register operands and a funct3 op code on a start pulse, computes over a fixed number of cycles, and presents a registered result.
- Sits directly upstream of the writeback-select mux. Its result_out feeds one data input of that mux; done_out qualifies the select.

Parameters:
- N, 32, operand/result width in bits; also the iteration count.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- start_in  input  1  request pulse; sampled only in IDLE.
- funct3_in  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_in  input  N  operand A (multiplicand / dividend).
- rs2_in  input  N  operand B (multiplier / divisor).
- busy_out  output  1  high while an operation is in flight (state != IDLE).
- done_out  output  1  one-cycle pulse; result_out is valid for the new operation.
- result_out  output  N  registered result; holds until the next done_out.

Behaviour:
- Clocking and reset:
  - Single clock domain (clk_in). Reset is synchronous and active-high (rst_in).
  - On reset: state=IDLE, busy_out=0, done_out=0, result_out=0, counter=0, internal operand registers=0.
  - Reset asserted mid-operation aborts the operation. No done_out is produced for it.
- States and transitions:
  - IDLE -> CALC when start_in=1 at edge k. At that edge, latch funct3, operand magnitudes, and sign flags; clear the counter and accumulator.
  - CALC: one iteration per edge, edges k+1..k+N. Advance to FIX at edge k+N.
  - FIX: at edge k+N+1, apply sign/special-case correction, register result_out, set done_out=1, return to IDLE.
- Timing:
  - done_out is high for exactly the one cycle after edge k+N+1 and drops at the next edge.
  - Fixed latency is N+1 edges for every op, including special cases.
  - Back-to-back operation is allowed: start_in sampled at edge k+N+2 (while done_out=1) is accepted.
- Input handling:
  - start_in while busy_out=1 is ignored; there is no queueing.
  - Operand and funct3 changes after the start edge have no effect.
- Multiply:
  - Shift-add on 2N-bit unsigned magnitudes.
  - MUL returns the low N bits. MULH, MULHSU, and MULHU return the high N bits.
  - Signedness: MULH treats both operands as signed; MULHSU treats rs1 as signed and rs2 as unsigned; MULHU treats both as unsigned.
  - Negation of the 2N-bit product is applied in FIX when exactly one signed operand is negative.
- Divide:
  - Restoring division on unsigned magnitudes, one quotient bit per iteration.
  - Quotient sign = sign(rs1) xor sign(rs2). Remainder sign = sign(rs1).
  - Divide by zero: DIV/DIVU return all ones (0xFFFFFFFF); REM/REMU return rs1 unchanged.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV returns 0x80000000, REM returns 0.
  - Special cases are resolved in FIX; latency is unchanged.
- Outputs:
  - result_out never changes except at the FIX edge or on reset.
  - busy_out is combinational from state: 1 in CALC and FIX, 0 in IDLE.

Test Plan:
- Reset, then MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> done_out pulses at cycle N+2 after start; result_out=0xFFFFFFEB; busy_out high for exactly N+1 cycles.
- MULH / MULHSU / MULHU with rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0x00000000 / 0xFFFFFFFF / 0xFFFFFFFE.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5. Overflow: DIV 0x80000000/-1 -> 0x80000000, REM -> 0. Latency identical to a normal op.
- Start pulse during busy with different operands is ignored and the first result is delivered. A start during the done_out cycle is accepted, producing back-to-back done pulses N+2 cycles apart.
- rst_in asserted at iteration 10 of a DIV -> next cycle busy_out=0, result_out=0, and no done_out. A fresh MUL 3x4 afterwards -> 12.
